// File: rtl/clk_divide_by_n.sv
// clk_divide_by_n: programmable 50%-duty clock divider, N = 2..2^WIDTH-1.
// New divisors are staged and switch in only at a period boundary.
//
// Ports:
//   clk          source clock for all logic
//   rst          asynchronous active-high reset
//   div_val      requested divisor N (0 and 1 are treated as 2)
//   div_load     capture div_val into the pending slot on a clk posedge
//   out_clk      divided clock, clk/N, 50% duty (odd N via negedge flop)
//   out_tick     one-cycle strobe during the first cycle of each period
//   load_pending a captured divisor is waiting for the next wrap
module clk_divide_by_n #(
  parameter int WIDTH   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             out_clk,
  output logic             out_tick,
  output logic             load_pending
);

  localparam logic [WIDTH-1:0] DEF_W = WIDTH'(DEF_DIV);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO_W = WIDTH'(2);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pval_q, pval_d;
  logic             pend_q, pend_d;
  logic             pos_q, pos_d;
  logic             tick_q, tick_d;
  logic             neg_q;

  logic             wrap;
  logic [WIDTH-1:0] load_val;

  assign wrap     = (cnt_q == div_q - ONE_W);
  assign load_val = (div_val < TWO_W) ? TWO_W : div_val;

  always_comb begin
    cnt_d  = cnt_q + ONE_W;
    div_d  = div_q;
    pval_d = pval_q;
    pend_d = pend_q;
    if (wrap) begin
      cnt_d = '0;
      if (pend_q) begin
        div_d  = pval_q;
        pend_d = 1'b0;
      end
    end
    // A load on the wrap edge is staged after the swap above,
    // so it waits for the following wrap.
    if (div_load) begin
      pval_d = load_val;
      pend_d = 1'b1;
    end
    // Posedge flop covers floor(N/2) cycles; for odd N the
    // negedge flop stretches the high phase by half a cycle.
    pos_d  = (cnt_d < (div_d >> 1));
    tick_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= DEF_W - ONE_W;
      div_q  <= DEF_W;
      pval_q <= DEF_W;
      pend_q <= 1'b0;
      pos_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      pval_q <= pval_d;
      pend_q <= pend_d;
      pos_q  <= pos_d;
      tick_q <= tick_d;
    end
  end

  // Delayed copy of pos_q, only for odd divisors.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_q & div_q[0];
    end
  end

  assign out_clk      = pos_q | neg_q;
  assign out_tick     = tick_q;
  assign load_pending = pend_q;

endmodule

// File: tb/tb_clk_divide_by_n.sv
// tb_clk_divide_by_n: directed and random checks of clk_divide_by_n
// against a period/phase arithmetic model of the divider.
module tb_clk_divide_by_n;

  localparam int W   = 8;
  localparam int DEF = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         div_load = 1'b0;
  logic [W-1:0] div_val = '0;
  logic         out_clk;
  logic         out_tick;
  logic         load_pending;

  int total = 0;
  int bad   = 0;

  // model: k = cycles into current period, n = active divisor
  int m_k, m_n, m_pv;
  bit m_p;
  int hi_halves;

  clk_divide_by_n #(.WIDTH(W), .DEF_DIV(DEF)) dut (
    .clk          (clk),
    .rst          (rst),
    .div_val      (div_val),
    .div_load     (div_load),
    .out_clk      (out_clk),
    .out_tick     (out_tick),
    .load_pending (load_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_k = DEF - 1;
    m_n = DEF;
    m_p = 0;
  endfunction

  function automatic void m_edge(input bit ld, input int v);
    if (rst) begin
      m_reset();
      return;
    end
    if (m_k == m_n - 1) begin
      m_k = 0;
      if (m_p) begin
        m_n = m_pv;
        m_p = 0;
      end
    end else begin
      m_k++;
    end
    if (ld) begin
      m_pv = (v < 2) ? 2 : v;
      m_p  = 1;
    end
  endfunction

  // First half of a cycle is high for k < ceil(N/2),
  // second half for k < floor(N/2).
  function automatic logic exp_first();
    return !rst && (m_k < (m_n + 1) / 2);
  endfunction

  function automatic logic exp_second();
    return !rst && (m_k < m_n / 2);
  endfunction

  task automatic step(input bit ld, input int v);
    div_load = ld;
    div_val  = W'(v);
    @(posedge clk);
    m_edge(ld, v);
    #1;
    chk("clk_h1", out_clk, exp_first());
    chk("tick", out_tick, !rst && m_k == 0);
    chk("pend", load_pending, m_p);
    hi_halves += out_clk;
    @(negedge clk);
    #1;
    chk("clk_h2", out_clk, exp_second());
    hi_halves += out_clk;
    div_load = 1'b0;
  endtask

  // run until the next posedge will start a new period
  task automatic to_wrap();
    int i;
    i = 0;
    while (m_k != m_n - 1 && i < 300) begin
      step(0, 0);
      i++;
    end
    if (m_k != m_n - 1) chk("wrap_timeout", 0, 1);
  endtask

  initial begin
    m_reset();
    hi_halves = 0;
    #1 rst = 1'b1;
    #1;
    chk("rst_clk", out_clk, 0);
    chk("rst_tick", out_tick, 0);
    chk("rst_pend", load_pending, 0);
    @(negedge clk);
    #1;
    step(1, 9);
    step(0, 0);
    rst = 1'b0;

    // default N=2
    repeat (6) step(0, 0);

    // N=6 then N=5 with duty measurement
    step(1, 6);
    to_wrap();
    repeat (13) step(0, 0);
    step(1, 5);
    to_wrap();
    step(0, 0);
    to_wrap();
    hi_halves = 0;
    repeat (5) step(0, 0);
    chk("duty5", hi_halves, 5);

    // 7 then 3 in one period, 4 on the wrap edge
    step(1, 7);
    step(1, 3);
    to_wrap();
    step(1, 4);
    chk("n_after_wrap", m_n, 3);
    repeat (10) step(0, 0);

    // 0 and 1 behave as 2
    step(1, 0);
    repeat (8) step(0, 0);
    step(1, 1);
    repeat (8) step(0, 0);

    // async reset mid-high with N=9 and a pending load
    step(1, 9);
    to_wrap();
    step(0, 0);
    step(1, 5);
    @(posedge clk);
    m_edge(0, 0);
    #2;
    chk("pre_rst_hi", out_clk, 1);
    rst = 1'b1;
    #1;
    m_reset();
    chk("arst_clk", out_clk, 0);
    chk("arst_tick", out_tick, 0);
    chk("arst_pend", load_pending, 0);
    @(negedge clk);
    #1;
    step(1, 7);
    rst = 1'b0;
    repeat (6) step(0, 0);

    // random loads
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 7) == 0, int'($urandom_range(0, 12)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
